// File: rtl/wrr_guard_arbiter.sv
// wrr_guard_arbiter: shares one egress transmitter between a strict-priority H server and
// N weighted-round-robin L servers. Grants are active-low ena_n pulses held until the chosen
// server answers with bool_go or a TMO-cycle timeout expires.
// Optional feature: define WRR_GUARD_BAND_EN to block any L start whose head-frame length
// exceeds the cycles left before the next TT window (tt_gap).
module wrr_guard_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned WGT_W = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned TMO   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bool_ready_H,
  input  logic               bool_go_H,
  input  logic [N-1:0]       bool_ready_L,
  input  logic [N-1:0]       bool_go_L,
  input  logic [N*LEN_W-1:0] pkt_len_L,
  input  logic [N*WGT_W-1:0] weight_L,
  input  logic [LEN_W-1:0]   tt_gap,
  output logic               ena_n_H,
  output logic [N-1:0]       ena_n_L,
  output logic [1:0]         active,
  output logic [3:0]         channel,
  output logic               err_conflict
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  localparam logic [1:0] ActNone = 2'b00;
  localparam logic [1:0] ActH    = 2'b01;
  localparam logic [1:0] ActL    = 2'b10;

  typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

  state_e            state_q, state_d;
  logic [1:0]        act_q, act_d;
  logic [3:0]        chan_q, chan_d;
  logic [N-1:0]      oh_q, oh_d;     // one-hot of the L owner
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [WGT_W-1:0]  cred_q, cred_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q;

  logic [N-1:0]      elig;
  logic [PW-1:0]     win, idx;
  logic              win_found, reload;
  logic [N-1:0]      win_oh;
  logic [WGT_W-1:0]  wsel;
  logic              own_go, conflict;

  // Eligibility of each L channel, optionally gated by the guard band.
  always_comb begin
    elig = bool_ready_L;
`ifdef WRR_GUARD_BAND_EN
    for (int i = 0; i < N; i++) begin
      if (pkt_len_L[i*LEN_W +: LEN_W] > tt_gap) elig[i] = 1'b0;
    end
`endif
  end

`ifndef WRR_GUARD_BAND_EN
  logic unused_guard;
  assign unused_guard = ^{tt_gap, pkt_len_L};
`endif

  // WRR winner: keep ptr while it has credit, else next eligible channel after ptr.
  always_comb begin
    win       = '0;
    idx       = '0;
    win_found = 1'b0;
    reload    = 1'b0;
    if (elig[ptr_q] && cred_q != '0) begin
      win       = ptr_q;
      win_found = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = PW'((int'(ptr_q) + k) % N);
        if (!win_found && elig[idx]) begin
          win       = idx;
          win_found = 1'b1;
          reload    = 1'b1;
        end
      end
    end
    wsel   = '0;
    win_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        wsel      = weight_L[i*WGT_W +: WGT_W];
        win_oh[i] = 1'b1;
      end
    end
  end

  // Owner's go and conflict detection against the registered owner.
  always_comb begin
    own_go   = (act_q == ActH) ? bool_go_H : |(bool_go_L & oh_q);
    conflict = 1'b0;
    if (state_q == StIdle) begin
      conflict = bool_go_H | (|bool_go_L);
    end else if (act_q == ActH) begin
      conflict = |bool_go_L;
    end else begin
      conflict = bool_go_H | (|(bool_go_L & ~oh_q));
    end
  end

  // Next-state logic for the IDLE/GRANT/BUSY scheduler and WRR bookkeeping.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    chan_d  = chan_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bool_ready_H) begin
          state_d = StGrant;
          act_d   = ActH;
          chan_d  = '0;
          oh_d    = '0;
          cnt_d   = '0;
        end else if (win_found) begin
          state_d = StGrant;
          act_d   = ActL;
          chan_d  = 4'(win);
          oh_d    = win_oh;
          cnt_d   = '0;
          if (reload) begin
            ptr_d  = win;
            cred_d = (wsel == '0) ? WGT_W'(1) : wsel;
          end
        end
      end
      StGrant: begin
        if (own_go) begin
          state_d = StBusy;
          if (act_q == ActL && cred_q != '0) cred_d = cred_q - WGT_W'(1);
        end else if (cnt_q == CW'(TMO - 1)) begin
          // Timeout: give up without consuming credit.
          state_d = StIdle;
          act_d   = ActNone;
          chan_d  = '0;
          oh_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StBusy: begin
        if (!own_go) begin
          state_d = StIdle;
          act_d   = ActNone;
          chan_d  = '0;
          oh_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      act_q   <= ActNone;
      chan_q  <= '0;
      oh_q    <= '0;
      ptr_q   <= PW'(N - 1);
      cred_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      chan_q  <= chan_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | conflict;
    end
  end

  assign ena_n_H      = !(state_q == StGrant && act_q == ActH);
  assign ena_n_L      = (state_q == StGrant && act_q == ActL) ? ~oh_q : '1;
  assign active       = act_q;
  assign channel      = chan_q;
  assign err_conflict = err_q;

endmodule

// File: tb/tb_wrr_guard_arbiter.sv
// Directed bench for wrr_guard_arbiter (N=3, WGT_W=4, LEN_W=8, TMO=4).
module tb_wrr_guard_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bool_ready_H, bool_go_H;
  logic [2:0]  bool_ready_L, bool_go_L;
  logic [23:0] pkt_len_L;
  logic [11:0] weight_L;
  logic [7:0]  tt_gap;
  logic        ena_n_H;
  logic [2:0]  ena_n_L;
  logic [1:0]  active;
  logic [3:0]  channel;
  logic        err_conflict;

  int total = 0;
  int bad   = 0;
  int who;

  always #5 clk = ~clk;

  wrr_guard_arbiter #(.N(3), .WGT_W(4), .LEN_W(8), .TMO(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bool_ready_H (bool_ready_H),
    .bool_go_H    (bool_go_H),
    .bool_ready_L (bool_ready_L),
    .bool_go_L    (bool_go_L),
    .pkt_len_L    (pkt_len_L),
    .weight_L     (weight_L),
    .tt_gap       (tt_gap),
    .ena_n_H      (ena_n_H),
    .ena_n_L      (ena_n_L),
    .active       (active),
    .channel      (channel),
    .err_conflict (err_conflict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bool_ready_H = 1'b0;
    bool_go_H    = 1'b0;
    bool_ready_L = '0;
    bool_go_L    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a grant, answer it with go for 'hold' cycles; who=15 for H, else channel.
  task automatic serve(input int hold, output int w);
    w = -1;
    for (int i = 0; i < 12 && w < 0; i++) begin
      if (!ena_n_H) w = 15;
      else if (ena_n_L != 3'b111) begin
        for (int j = 0; j < 3; j++) if (!ena_n_L[j]) w = j;
      end
      if (w < 0) tick();
    end
    check("grant_seen", 32'(w >= 0), 32'd1);
    if (w < 0) return;
    if (w == 15) bool_go_H = 1'b1;
    else bool_go_L[w] = 1'b1;
    tick();
    check("ena_release", {28'd0, ena_n_H, ena_n_L}, 32'hf);
    repeat (hold - 1) tick();
    bool_go_H = 1'b0;
    bool_go_L = '0;
    tick();
    check("idle_after_busy", 32'(active), 32'd0);
  endtask

  initial begin
    weight_L  = {4'd1, 4'd2, 4'd3};
    tt_gap    = 8'hff;
    pkt_len_L = '0;
    do_reset();

    // Reset values
    check("rst_ena_n_H", 32'(ena_n_H), 32'd1);
    check("rst_ena_n_L", 32'(ena_n_L), 32'h7);
    check("rst_active", 32'(active), 32'd0);
    check("rst_channel", 32'(channel), 32'd0);
    check("rst_err", 32'(err_conflict), 32'd0);
    tick();
    check("rst_hold_active", 32'(active), 32'd0);

    // Single L request on ch1
    bool_ready_L = 3'b010;
    tick();
    check("l1_ena_n_L", 32'(ena_n_L), 32'h5);
    check("l1_active", 32'(active), 32'h2);
    check("l1_channel", 32'(channel), 32'd1);
    check("l1_ena_n_H", 32'(ena_n_H), 32'd1);
    bool_go_L[1] = 1'b1;
    bool_ready_L = '0;
    tick();
    check("l1_busy_ena", 32'(ena_n_L), 32'h7);
    check("l1_busy_active", 32'(active), 32'h2);
    check("l1_busy_channel", 32'(channel), 32'd1);

    // Foreign go while ch1 is busy sets the sticky error
    bool_go_L[0] = 1'b1;
    check("conf_not_yet", 32'(err_conflict), 32'd0);
    tick();
    check("conf_set", 32'(err_conflict), 32'd1);
    bool_go_L = '0;
    tick();
    tick();
    check("conf_sticky", 32'(err_conflict), 32'd1);
    check("conf_idle", 32'(active), 32'd0);
    do_reset();
    check("conf_cleared", 32'(err_conflict), 32'd0);

    // H strict priority over all L
    bool_ready_H = 1'b1;
    bool_ready_L = 3'b111;
    for (int n = 0; n < 3; n++) begin
      serve(8, who);
      check("h_only", who, 32'd15);
    end
    check("h_no_conflict", 32'(err_conflict), 32'd0);

    // WRR sequence with weights {1,2,3}
    do_reset();
    bool_ready_L = 3'b111;
    begin
      int exp_seq[9] = '{0, 0, 0, 1, 1, 2, 0, 0, 0};
      for (int n = 0; n < 9; n++) begin
        serve(2, who);
        check("wrr_seq", who, exp_seq[n]);
      end
    end
    check("wrr_no_conflict", 32'(err_conflict), 32'd0);

    // Timeout: no go, ena_n low for exactly TMO cycles, same channel re-granted
    do_reset();
    bool_ready_L = 3'b001;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("tmo_low", 32'(ena_n_L), 32'h6);
    end
    tick();
    check("tmo_released", 32'(ena_n_L), 32'h7);
    check("tmo_idle", 32'(active), 32'd0);
    tick();
    check("tmo_regrant", 32'(ena_n_L), 32'h6);
    bool_ready_L = 3'b111;
    begin
      int exp_t[4] = '{0, 0, 0, 1};
      for (int n = 0; n < 4; n++) begin
        serve(2, who);
        check("tmo_cred_kept", who, exp_t[n]);
      end
    end

`ifdef WRR_GUARD_BAND_EN
    // Guard band: only ch1 fits a 10-cycle gap
    do_reset();
    tt_gap       = 8'd10;
    pkt_len_L    = {8'd12, 8'd6, 8'd20};
    bool_ready_L = 3'b111;
    for (int n = 0; n < 3; n++) begin
      serve(2, who);
      check("guard_ch1_only", who, 32'd1);
    end
    do_reset();
    tt_gap       = 8'd25;
    bool_ready_L = 3'b111;
    serve(2, who);
    check("guard_wide_gap", who, 32'd0);
`else
    // Guard disabled: tt_gap is ignored
    do_reset();
    tt_gap       = 8'd0;
    pkt_len_L    = {8'd12, 8'd6, 8'd20};
    bool_ready_L = 3'b111;
    serve(2, who);
    check("noguard_ch0", who, 32'd0);
    serve(2, who);
    check("noguard_ch0_again", who, 32'd0);
`endif

    // Async reset in BUSY, then lingering go is a conflict once reset lifts
    do_reset();
    bool_ready_L = 3'b100;
    tick();
    check("mid_grant_ch2", 32'(ena_n_L), 32'h3);
    bool_go_L[2] = 1'b1;
    bool_ready_L = '0;
    tick();
    check("mid_busy_channel", 32'(channel), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_channel", 32'(channel), 32'd0);
    check("mid_rst_ena", 32'(ena_n_L), 32'h7);
    tick();
    check("mid_rst_err_held", 32'(err_conflict), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_post_err", 32'(err_conflict), 32'd1);
    bool_go_L = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_guard_arbiter.md
# wrr_guard_arbiter

Ready/go scheduler that shares the single egress transmitter between one high-priority (TT) server and N low-priority (RC/BE) servers. The H class has strict priority; the L classes are served weighted round-robin, with an optional guard band that blocks any L start whose packet would overrun the next TT window. It sits between the `q_server_3_states` instances and the transmitter. It drives their `ena_n` lines and tracks their `bool_go` responses.

## Interface
- `N`, default 3: number of low-priority requesters (1..15).
- `WGT_W`, default 4: width of each per-channel weight.
- `LEN_W`, default 8: width of packet length and TT gap, in cycles.
- `TMO`, default 4: cycles to wait for `bool_go` after a grant.
- `clk`, in, 1: single clock; all logic on posedge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `bool_ready_H`, in, 1: H server has a frame pending.
- `bool_go_H`, in, 1: H server is transmitting.
- `bool_ready_L`, in, N: L servers have frames pending.
- `bool_go_L`, in, N: L servers are transmitting.
- `pkt_len_L`, in, N*LEN_W: head-frame length per L channel; channel i occupies bits [i*LEN_W +: LEN_W].
- `weight_L`, in, N*WGT_W: grants per round per L channel; a weight of 0 is treated as 1.
- `tt_gap`, in, LEN_W: cycles until the next TT window opens, from the timetable translator.
- `ena_n_H`, out, 1: active-low grant to the H server.
- `ena_n_L`, out, N: active-low grants to the L servers.
- `active`, out, 2: owner of the transmitter. 00 = none, 01 = H, 10 = L.
- `channel`, out, 4: binary index of the granted L channel. Reads 0 when H owns the transmitter or nobody does.
- `err_conflict`, out, 1: sticky error flag, cleared only by reset.

## Operation
- FSM states are IDLE, GRANT and BUSY.
- IDLE:
  - If `bool_ready_H` is set, grant H.
  - Otherwise, if any eligible L channel exists, grant the WRR winner.
  - Otherwise stay in IDLE.
- GRANT:
  - Hold the chosen `ena_n` low.
  - When the chosen `bool_go` is sampled high, release `ena_n` and go to BUSY.
  - If `bool_go` is not seen within TMO cycles, release `ena_n` and go to IDLE. No weight is consumed.
- BUSY: hold `active` and `channel`. When the owner's `bool_go` is sampled low, go to IDLE.
- WRR:
  - Keep a pointer `ptr` and a credit counter `cred` (WGT_W bits).
  - If `ptr` is eligible and `cred` > 0, `ptr` wins.
  - Otherwise the next eligible channel after `ptr`, in ascending order and wrapping modulo N, wins. `ptr` moves to it and `cred` reloads to max(weight,1).
  - On entry to BUSY for an L grant, `cred` decrements by 1, saturating at 0.
- Eligibility: `bool_ready_L[i]`, further gated by the guard rule (see Configuration).
- An H grant does not change `ptr` or `cred`.
- Conflict: `err_conflict` sets if, in any cycle, a `bool_go` is high that is not the current owner's. The owner is whoever `active`/`channel` identify during GRANT or BUSY. In IDLE, any `bool_go` counts as a conflict.
- Reset values:
  - All `ena_n` = 1, `active` = 00, `channel` = 0, `err_conflict` = 0.
  - State = IDLE, `ptr` = N-1, `cred` = 0. The first L grant therefore goes to channel 0.

## Timing
- Arbitration latency: `ena_n` goes low on the first posedge after ready is sampled in IDLE (1 cycle).
- `active` and `channel` update on the same edge as `ena_n`.
- `ena_n` returns high on the edge that samples `bool_go` = 1.
- IDLE always lasts at least 1 cycle between frames, so a ready that rises during BUSY is granted 2 cycles after the owner's `bool_go` falls.
- H and L ready together: H wins. The L request is still pending and is served on the next IDLE with no H ready.
- Ready withdrawn during GRANT: `ena_n` stays asserted until `bool_go` arrives or the timeout expires.
- A change in `weight_L` takes effect at the next `cred` reload.
- Asynchronous reset mid-BUSY: all outputs return to their reset values immediately. Any in-flight `bool_go` is then seen from IDLE and sets `err_conflict` only after reset is released.

## Configuration
- `WRR_GUARD_BAND_EN` defined: L channel i is eligible only if `pkt_len_L[i]` <= `tt_gap` (unsigned, LEN_W bits). H is never guarded.
- `WRR_GUARD_BAND_EN` undefined: `tt_gap` is ignored and eligibility is `bool_ready_L` alone.

## Test plan
- Reset release with all ready = 0 → outputs hold their reset values. Set `bool_ready_L[1]` = 1 → `ena_n_L` = 3'b101, `active` = 10, `channel` = 1 one cycle later.
- `bool_ready_H` and all `bool_ready_L` held high, each server's go pulse lasting 8 cycles → only H is granted. `err_conflict` stays 0.
- Weights {ch2, ch1, ch0} = {1, 2, 3}, all L ready continuously, H idle → grant sequence 0,0,0,1,1,2,0,0,0,…
- Grant issued but the server never raises go, TMO = 4 → `ena_n` low for 4 cycles, then IDLE. `cred` is unchanged and the same channel is re-granted.
- With `WRR_GUARD_BAND_EN` defined: `tt_gap` = 10, `pkt_len_L` = {12, 6, 20} for {ch2, ch1, ch0}, all ready → only ch1 is granted. With `tt_gap` = 25 → ch0 wins first.
- Force `bool_go_L[0]` high while ch1 owns BUSY → `err_conflict` = 1 next cycle and stays 1 until `rst_n` is asserted.
